riscv_v_bitwise_unit: RTL and testbench

Pipelined, multi-beat successor to the single-function bitwise gate of the vector datapath. Processes one DATA_WIDTH slice of a vector register group per beat and supports eight bitwise functions with per-element masking (mask-undisturbed) and optional cross-beat reductions (vredand/vredor/vredxor). Sits in the vector execution lane between operand read and writeback, with valid/ready handshakes on both sides.

---
 rtl/riscv_v_bitwise_unit_pkg.sv | 66 ++++++
 rtl/riscv_v_bitwise_unit_if.sv | 33 +++
 rtl/riscv_v_bitwise_unit_lane.sv | 41 ++++
 rtl/riscv_v_bitwise_unit.sv | 168 ++++++++++++++++
 tb/tb_riscv_v_bitwise_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_v_bitwise_unit_pkg.sv
// riscv_v_pkg: shared definitions for the vector bitwise unit.
//   bitwise_op_e       - 3-bit function encoding (AND=0 ... NOR=7)
//   bitwise_apply      - element-wise function on OPND_W-wide operands
//   red_op_legalize    - maps a reduction op onto AND/OR/XOR
//   RED_ID_*           - reduction identity constants (inactive element value)
// Operands are carried at OPND_W bits; callers zero-extend and truncate,
// so ELEM_WIDTH may not exceed OPND_W.
package riscv_v_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_ANDN = 3'd3,
    OP_ORN  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NAND = 3'd6,
    OP_NOR  = 3'd7
  } bitwise_op_e;

  localparam int unsigned OPND_W = 64;

  localparam logic [OPND_W-1:0] RED_ID_AND = {OPND_W{1'b1}};
  localparam logic [OPND_W-1:0] RED_ID_OR  = {OPND_W{1'b0}};
  localparam logic [OPND_W-1:0] RED_ID_XOR = {OPND_W{1'b0}};

  function automatic logic [OPND_W-1:0] bitwise_apply(bitwise_op_e op,
                                                      logic [OPND_W-1:0] a,
                                                      logic [OPND_W-1:0] b);
    logic [OPND_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Reductions only support AND/OR/XOR; every other code reduces as AND.
  function automatic bitwise_op_e red_op_legalize(bitwise_op_e op);
    bitwise_op_e r;
    case (op)
      OP_OR:   r = OP_OR;
      OP_XOR:  r = OP_XOR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  function automatic logic [OPND_W-1:0] red_identity(bitwise_op_e op);
    logic [OPND_W-1:0] r;
    case (op)
      OP_OR:   r = RED_ID_OR;
      OP_XOR:  r = RED_ID_XOR;
      default: r = RED_ID_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_v_bitwise_unit_if.sv
// riscv_v_bitwise_unit_if: beat-in / result-out handshake bundle.
//   master - producer side (drives in_*, out_ready)
//   slave  - the bitwise unit (drives in_ready, out_valid, out_S, out_last)
interface riscv_v_bitwise_unit_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ELEM_WIDTH = 8
);
  localparam int unsigned NE = DATA_WIDTH / ELEM_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic                  in_red;
  logic [DATA_WIDTH-1:0] in_A;
  logic [DATA_WIDTH-1:0] in_B;
  logic [DATA_WIDTH-1:0] in_old;
  logic [NE-1:0]         in_mask;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_S;
  logic                  out_last;

  modport master (
    output in_valid, in_op, in_red, in_A, in_B, in_old, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_S, out_last
  );

  modport slave (
    input  in_valid, in_op, in_red, in_A, in_B, in_old, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_S, out_last
  );
endinterface

// File: rtl/riscv_v_bitwise_unit_lane.sv
// riscv_v_bitwise_lane: one ELEM_WIDTH element of the bitwise unit.
//   op/a/b  - function and operands
//   old     - previous destination element, kept when the element is inactive
//   active  - element mask bit
//   res     - combinational result
module riscv_v_bitwise_lane
  import riscv_v_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH = 8
) (
  input  bitwise_op_e           op,
  input  logic [ELEM_WIDTH-1:0] a,
  input  logic [ELEM_WIDTH-1:0] b,
  input  logic [ELEM_WIDTH-1:0] old,
  input  logic                  active,
  output logic [ELEM_WIDTH-1:0] res
);
  logic [OPND_W-1:0] a_x_s;
  logic [OPND_W-1:0] b_x_s;
  logic [OPND_W-1:0] f_x_s;

  // Widen operands to the package width, apply the op and select against old.
  always_comb begin
    a_x_s = {OPND_W{1'b0}};
    b_x_s = {OPND_W{1'b0}};
    a_x_s[ELEM_WIDTH-1:0] = a;
    b_x_s[ELEM_WIDTH-1:0] = b;
    f_x_s = bitwise_apply(op, a_x_s, b_x_s);
    if (active) begin
      res = f_x_s[ELEM_WIDTH-1:0];
    end else begin
      res = old;
    end
  end

  // The widened upper bits of the result carry no information.
  if (ELEM_WIDTH < OPND_W) begin : g_sink
    logic unused_hi_s;
    assign unused_hi_s = ^f_x_s[OPND_W-1:ELEM_WIDTH];
  end
endmodule

// File: rtl/riscv_v_bitwise_unit.sv
// riscv_v_bitwise_unit: pipelined multi-beat vector bitwise unit.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - riscv_v_bitwise_unit_if.slave (beat input, result output)
// One result register, 1-cycle latency, in_ready = !out_valid || out_ready.
// Element-wise results are mask-undisturbed. Reductions (vredand/or/xor)
// are compiled in only when RISCV_V_BITWISE_RED_EN is defined; otherwise
// in_red is ignored and every packet is element-wise.
module riscv_v_bitwise_unit
  import riscv_v_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned MAX_BEATS  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  riscv_v_bitwise_unit_if.slave  bus
);
  localparam int unsigned NE = DATA_WIDTH / ELEM_WIDTH;
  localparam int unsigned CW = $clog2(MAX_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  logic [CW-1:0]         beat_cnt_r;
  bitwise_op_e           op_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_s_r;
  logic                  out_last_r;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  first_s;
  logic                  end_s;
  logic                  red_s;
  logic                  produce_s;
  bitwise_op_e           op_s;
  logic [DATA_WIDTH-1:0] ew_res_s;
  logic [DATA_WIDTH-1:0] res_next_s;

  assign in_ready_s    = !out_valid_r || bus.out_ready;
  assign accept_s      = bus.in_valid && in_ready_s;
  assign first_s       = (beat_cnt_r == {CW{1'b0}});
  // A packet ends on in_last or when the MAX_BEATS-th beat is accepted.
  assign end_s         = bus.in_last || (beat_cnt_r == LAST_BEAT);
  // op/red come from the bus on the first beat, from the latch afterwards.
  assign op_s          = first_s ? bitwise_op_e'(bus.in_op) : op_r;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_S     = out_s_r;
  assign bus.out_last  = out_last_r;

  for (genvar g = 0; g < NE; g++) begin : g_lane
    riscv_v_bitwise_lane #(.ELEM_WIDTH(ELEM_WIDTH)) u_lane (
      .op     (op_s),
      .a      (bus.in_A[g*ELEM_WIDTH +: ELEM_WIDTH]),
      .b      (bus.in_B[g*ELEM_WIDTH +: ELEM_WIDTH]),
      .old    (bus.in_old[g*ELEM_WIDTH +: ELEM_WIDTH]),
      .active (bus.in_mask[g]),
      .res    (ew_res_s[g*ELEM_WIDTH +: ELEM_WIDTH])
    );
  end

`ifdef RISCV_V_BITWISE_RED_EN
  logic                  red_r;
  logic [ELEM_WIDTH-1:0] acc_r;
  logic [ELEM_WIDTH-1:0] red_val_s;
  bitwise_op_e           red_op_s;
  logic [OPND_W-1:0]     fold_x_s;
  logic [OPND_W-1:0]     elem_x_s;

  assign red_s = first_s ? bus.in_red : red_r;

  // Fold the seed (first beat) or running accumulator with this beat's
  // elements; inactive elements fold in the identity and so contribute nothing.
  always_comb begin
    red_op_s = red_op_legalize(op_s);
    fold_x_s = {OPND_W{1'b0}};
    elem_x_s = {OPND_W{1'b0}};
    if (first_s) begin
      fold_x_s[ELEM_WIDTH-1:0] = bus.in_B[ELEM_WIDTH-1:0];
    end else begin
      fold_x_s[ELEM_WIDTH-1:0] = acc_r;
    end
    for (int i = 0; i < NE; i++) begin
      if (bus.in_mask[i]) begin
        elem_x_s = {OPND_W{1'b0}};
        elem_x_s[ELEM_WIDTH-1:0] = bus.in_A[i*ELEM_WIDTH +: ELEM_WIDTH];
      end else begin
        elem_x_s = red_identity(red_op_s);
      end
      fold_x_s = bitwise_apply(red_op_s, fold_x_s, elem_x_s);
    end
    red_val_s = fold_x_s[ELEM_WIDTH-1:0];
  end

  // Reduction mode latch and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_r <= 1'b0;
      acc_r <= {ELEM_WIDTH{1'b0}};
    end else if (accept_s) begin
      if (first_s) begin
        red_r <= bus.in_red;
      end
      if (red_s) begin
        acc_r <= red_val_s;
      end
    end
  end

  // Reduction results carry the value in element 0, zeros elsewhere.
  always_comb begin
    produce_s  = !red_s || end_s;
    res_next_s = ew_res_s;
    if (red_s) begin
      res_next_s = {DATA_WIDTH{1'b0}};
      res_next_s[ELEM_WIDTH-1:0] = red_val_s;
    end else begin
      res_next_s = ew_res_s;
    end
  end
`else
  logic unused_red_s;
  assign unused_red_s = bus.in_red;
  assign red_s        = 1'b0;

  // Without reductions every accepted beat produces its element-wise result.
  always_comb begin
    produce_s  = !red_s;
    res_next_s = ew_res_s;
  end
`endif

  // Beat counter and op latch; the counter wraps to 0 at every packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= {CW{1'b0}};
      op_r       <= OP_AND;
    end else if (accept_s) begin
      if (first_s) begin
        op_r <= bitwise_op_e'(bus.in_op);
      end
      if (end_s) begin
        beat_cnt_r <= {CW{1'b0}};
      end else begin
        beat_cnt_r <= beat_cnt_r + CW'(1'b1);
      end
    end
  end

  // Result register: load on a producing beat (replacing any result being
  // handed off this cycle), drop valid on handoff, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_s_r     <= {DATA_WIDTH{1'b0}};
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= produce_s;
      if (produce_s) begin
        out_s_r    <= res_next_s;
        out_last_r <= end_s;
      end
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_riscv_v_bitwise_unit.sv
// tb_riscv_v_bitwise_unit: directed + randomized bench for riscv_v_bitwise_unit
// (DATA_WIDTH=32, ELEM_WIDTH=8, MAX_BEATS=4) against a word-level model.
module tb_riscv_v_bitwise_unit;
`ifdef RISCV_V_BITWISE_RED_EN
  localparam bit RED_EN = 1'b1;
`else
  localparam bit RED_EN = 1'b0;
`endif
  localparam int MB = 4;

  typedef struct {
    logic [31:0] s;
    logic        last;
  } res_t;

  logic clk;
  logic rst_n;
  riscv_v_bitwise_unit_if #(.DATA_WIDTH(32), .ELEM_WIDTH(8)) bus ();

  riscv_v_bitwise_unit #(.DATA_WIDTH(32), .ELEM_WIDTH(8), .MAX_BEATS(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int out_cnt  = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  int          m_cnt = 0;
  logic [2:0]  m_op  = 3'd0;
  logic        m_red = 1'b0;
  logic [7:0]  m_acc = 8'd0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_s;
  logic        prev_last;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] word_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a & ~b;
      3'd4: return a | ~b;
      3'd5: return ~(a ^ b);
      3'd6: return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // Reference model: consumes one accepted beat, queues any expected result.
  task automatic model_accept();
    logic first, endp;
    logic [2:0] rop;
    logic [7:0] e;
    logic [31:0] mm, f;
    res_t x;
    first = (m_cnt == 0);
    if (first) begin
      m_op  = bus.in_op;
      m_red = RED_EN ? bus.in_red : 1'b0;
    end
    endp = bus.in_last || (m_cnt == MB - 1);
    if (!m_red) begin
      mm = 32'd0;
      for (int i = 0; i < 4; i++) mm[i*8 +: 8] = {8{bus.in_mask[i]}};
      f = word_op(m_op, bus.in_A, bus.in_B);
      x.s = (f & mm) | (bus.in_old & ~mm);
      x.last = endp;
      exp_q.push_back(x);
    end else begin
      rop = (m_op <= 3'd2) ? m_op : 3'd0;
      if (first) m_acc = bus.in_B[7:0];
      for (int i = 0; i < 4; i++) begin
        if (bus.in_mask[i]) begin
          e = bus.in_A[i*8 +: 8];
          if (rop == 3'd1) m_acc = m_acc | e;
          else if (rop == 3'd2) m_acc = m_acc ^ e;
          else m_acc = m_acc & e;
        end
      end
      if (endp) begin
        x.s = {24'd0, m_acc};
        x.last = 1'b1;
        exp_q.push_back(x);
      end
    end
    m_cnt = endp ? 0 : m_cnt + 1;
  endtask

  // Compare process: every falling edge, check handshake, hold and results.
  initial begin
    res_t x, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_cnt = 0; m_op = 3'd0; m_red = 1'b0; m_acc = 8'd0;
        hold_prev = 1'b0;
      end else begin
        chk("in_ready_rule", {31'd0, bus.in_ready}, {31'd0, !bus.out_valid || bus.out_ready});
        if (hold_prev) begin
          chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("hold_S", bus.out_S, prev_s);
          chk("hold_last", {31'd0, bus.out_last}, {31'd0, prev_last});
        end
        if (bus.out_valid && bus.out_ready) begin
          x.s = bus.out_S; x.last = bus.out_last;
          obs_q.push_back(x);
          out_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_S", bus.out_S, e.s);
            chk("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
          end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_s    = bus.out_S;
        prev_last = bus.out_last;
        if (bus.in_valid && bus.in_ready) model_accept();
      end
    end
  end

  task automatic drive(logic [2:0] op, logic red, logic [31:0] a, logic [31:0] b,
                       logic [31:0] old, logic [3:0] mask, logic last);
    bus.in_op = op; bus.in_red = red; bus.in_A = a; bus.in_B = b;
    bus.in_old = old; bus.in_mask = mask; bus.in_last = last;
  endtask

  // Offer one beat and wait (bounded) until it is accepted.
  task automatic send(logic [2:0] op, logic red, logic [31:0] a, logic [31:0] b,
                      logic [31:0] old, logic [3:0] mask, logic last);
    int k;
    @(posedge clk); #1;
    drive(op, red, a, b, old, mask, last);
    bus.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("accept_bound", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive(3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_S", bus.out_S, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("model_xor_pin", word_op(3'd2, 32'hF0F01234, 32'h0FF0FFFF), 32'hFF00EDCB);
    @(negedge clk); rst_n = 1'b1;

    // XOR, full mask
    obs_q.delete();
    send(3'd2, 1'b0, 32'hF0F01234, 32'h0FF0FFFF, 32'h0, 4'hF, 1'b1);
    settle();
    chk("xor_count", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) begin
      chk("xor_S", obs_q[0].s, 32'hFF00EDCB);
      chk("xor_last", {31'd0, obs_q[0].last}, 32'd1);
    end

    // Masked AND, mask-undisturbed
    obs_q.delete();
    send(3'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'hAAAAAAAA, 4'b0101, 1'b1);
    settle();
    chk("mand_count", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) chk("mand_S", obs_q[0].s, 32'hAA34AA78);

    // Backpressure: second beat must wait for the first result to leave
    obs_q.delete();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(3'd1, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 4'hF, 1'b1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(3'd7, 1'b0, 32'h00000000, 32'h0000FFFF, 32'h0, 4'hF, 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_held_S", bus.out_S, 32'h33333333);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_S", bus.out_S, 32'h FFFF0000);
    settle();
    chk("bp_count", obs_q.size(), 32'd2);
    if (obs_q.size() == 2) begin
      chk("bp_first", obs_q[0].s, 32'h33333333);
      chk("bp_second", obs_q[1].s, 32'hFFFF0000);
    end

    // Reduction OR over three beats
    obs_q.delete();
    send(3'd1, 1'b1, 32'h00000010, 32'h00000001, 32'h0, 4'hF, 1'b0);
    send(3'd1, 1'b1, 32'h02000000, 32'h00000001, 32'h0, 4'hF, 1'b0);
    send(3'd1, 1'b1, 32'h00000000, 32'h00000001, 32'h0, 4'hF, 1'b1);
    settle();
    if (RED_EN) begin
      chk("redor_count", obs_q.size(), 32'd1);
      if (obs_q.size() > 0) begin
        chk("redor_S", obs_q[0].s, 32'h00000013);
        chk("redor_last", {31'd0, obs_q[0].last}, 32'd1);
      end
    end else begin
      chk("redor_ew_count", obs_q.size(), 32'd3);
      if (obs_q.size() == 3) begin
        chk("redor_ew_S", obs_q[2].s, 32'h00000001);
        chk("redor_ew_last", {31'd0, obs_q[2].last}, 32'd1);
      end
    end

    // Beat overflow: forced end on 4th beat, 5th starts a new packet
    obs_q.delete();
    send(3'd2, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) send(3'd0, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 4'hF, 1'b0);
    send(3'd0, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 4'hF, 1'b0);
    send(3'd2, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 4'hF, 1'b1);
    settle();
    chk("ovf_count", obs_q.size(), 32'd6);
    if (obs_q.size() == 6) begin
      chk("ovf_r3_S", obs_q[2].s, 32'hF00FF00F);
      chk("ovf_r3_last", {31'd0, obs_q[2].last}, 32'd0);
      chk("ovf_r4_S", obs_q[3].s, 32'hF00FF00F);
      chk("ovf_r4_last", {31'd0, obs_q[3].last}, 32'd1);
      chk("ovf_r5_S", obs_q[4].s, 32'h0F000F00);
      chk("ovf_r5_last", {31'd0, obs_q[4].last}, 32'd0);
      chk("ovf_r6_S", obs_q[5].s, 32'h0F000F00);
    end

    // Reset mid-reduction, then a clean one-beat AND reduction
    send(3'd0, 1'b1, 32'h00FF00FF, 32'h000000F0, 32'h0, 4'hF, 1'b0);
    send(3'd0, 1'b1, 32'h0000FF00, 32'h000000F0, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_S", bus.out_S, 32'd0);
    chk("midrst_last", {31'd0, bus.out_last}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    send(3'd0, 1'b1, 32'h0F0F0F0F, 32'h000000FF, 32'h0, 4'hF, 1'b1);
    settle();
    chk("postrst_count", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) begin
      chk("postrst_S", obs_q[0].s, 32'h0000000F);
      chk("postrst_last", {31'd0, obs_q[0].last}, 32'd1);
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
